// File: rtl/mc_slave_result_arbiter_if.sv
// Slave-to-master result return bus for the RISC621 cluster arbiter.
// Carries per-slave request/data/ack/ready vectors plus the master offer handshake.
// slave modport: the arbiter's view; master modport: the cores/environment view.
interface mc_slave_result_arbiter_if #(
    parameter int NUM_SLAVES = 3,
    parameter int DATA_W     = 8,
    parameter int ID_W       = 2
);
    logic [NUM_SLAVES-1:0]        S_req;
    logic [NUM_SLAVES*DATA_W-1:0] S_data;
    logic [NUM_SLAVES-1:0]        S_ack;
    logic [NUM_SLAVES-1:0]        S_rdy;
    logic                         Bcast_rdy;
    logic                         M_valid;
    logic [DATA_W-1:0]            M_data;
    logic [ID_W-1:0]              M_id;
    logic                         M_ack;
    logic                         Arb_err;

    modport slave (
        input  S_req, S_data, S_rdy, M_ack,
        output S_ack, Bcast_rdy, M_valid, M_data, M_id, Arb_err
    );

    modport master (
        output S_req, S_data, S_rdy, M_ack,
        input  S_ack, Bcast_rdy, M_valid, M_data, M_id, Arb_err
    );
endinterface

// File: rtl/mc_slave_result_arbiter.sv
// Round-robin arbiter returning one slave result at a time to the master core, tagged with slave ID.
// Latency: S_req -> M_valid 1 cycle; M_ack -> S_ack pulse 1 cycle; peak rate 1 result / 3 cycles.
// Backpressure: the offer is held (data/ID stable) until M_ack; optional ARB_TIMEOUT_EN aborts a stalled offer.
//
// Ports: Clock_pin (rising edge), Reset_pin (synchronous, active high), bus (slave modport):
//   S_req/S_data/S_ack per-slave request, data and consume pulse; S_rdy -> Bcast_rdy (AND, combinational);
//   M_valid/M_data/M_id/M_ack master offer handshake; Arb_err sticky timeout flag.
// Optional feature macro: ARB_TIMEOUT_EN (abort an offer after TIMEOUT_CYC cycles without M_ack).
module mc_slave_result_arbiter #(
    parameter int NUM_SLAVES  = 3,
    parameter int DATA_W      = 8,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        Clock_pin,
    input  logic                        Reset_pin,
    mc_slave_result_arbiter_if.slave    bus
);

    // Elaboration-time parameter sanity checks.
    if ((2 ** ID_W) < NUM_SLAVES) begin : g_bad_id_w
        $error("ID_W too narrow for NUM_SLAVES");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_q,   state_d;
    logic [ID_W-1:0]         rr_ptr_q,  rr_ptr_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_W-1:0]       m_data_q,  m_data_d;
    logic [ID_W-1:0]         m_id_q,    m_id_d;
    logic [NUM_SLAVES-1:0]   s_ack_q,   s_ack_d;

    // Arbitration helpers
    logic                    grant_found;
    logic [ID_W-1:0]         grant_id;
    logic [DATA_W-1:0]       grant_data;
    logic [ID_W-1:0]         cand;
    logic [NUM_SLAVES-1:0]   win_oh;
    logic                    win_req;
    logic [ID_W-1:0]         rr_next;
    logic                    offer_done;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    err_q,    err_d;
`endif

    // (ptr + ofs) mod NUM_SLAVES, for ptr < NUM_SLAVES and ofs < NUM_SLAVES.
    function automatic logic [ID_W-1:0] rr_cand(input logic [ID_W-1:0] ptr, input int ofs);
        int s;
        s = int'(ptr) + ofs;
        if (s >= NUM_SLAVES) begin
            s = s - NUM_SLAVES;
        end
        return ID_W'(s);
    endfunction

    // Rotating priority search starting at rr_ptr; the first requester found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_data  = '0;
        cand        = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            cand = rr_cand(rr_ptr_q, i);
            for (int j = 0; j < NUM_SLAVES; j++) begin
                if (!grant_found && (ID_W'(j) == cand) && bus.S_req[j]) begin
                    grant_found = 1'b1;
                    grant_id    = cand;
                end
            end
        end
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (ID_W'(j) == grant_id) begin
                grant_data = bus.S_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // The latched ID doubles as the current winner for ack steering and release.
    always_comb begin
        win_oh = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            win_oh[j] = (ID_W'(j) == m_id_q);
        end
        win_req = |(bus.S_req & win_oh);
        rr_next = (m_id_q == ID_W'(NUM_SLAVES - 1)) ? '0 : m_id_q + ID_W'(1);
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_id_d     = m_id_q;
        s_ack_d    = '0;
        offer_done = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    m_valid_d = 1'b1;
                    m_data_d  = grant_data;
                    m_id_d    = grant_id;
                    state_d   = ST_OFFER;
`ifdef ARB_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end
            end
            ST_OFFER: begin
`ifdef ARB_TIMEOUT_EN
                if (bus.M_ack) begin
                    offer_done = 1'b1;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    // Counter value TIMEOUT_CYC-1 marks the last OFFER cycle.
                    offer_done = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    to_cnt_d   = to_cnt_q + TO_W'(1);
                end
`else
                offer_done = bus.M_ack;
`endif
                if (offer_done) begin
                    m_valid_d = 1'b0;
                    s_ack_d   = win_oh;
                    rr_ptr_d  = rr_next;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Hold off until the winner withdraws, so its stale request is never re-granted.
                if (!win_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_id_q    <= '0;
            s_ack_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_id_q    <= m_id_d;
            s_ack_q   <= s_ack_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.M_valid   = m_valid_q;
    assign bus.M_data    = m_data_q;
    assign bus.M_id      = m_id_q;
    assign bus.S_ack     = s_ack_q;
    assign bus.Bcast_rdy = &bus.S_rdy;
`ifdef ARB_TIMEOUT_EN
    assign bus.Arb_err   = err_q;
`else
    assign bus.Arb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mc_slave_result_arbiter.sv
// Directed bench for mc_slave_result_arbiter (3 slaves, 8-bit data).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Timeout scenario runs with TIMEOUT_CYC=4 when ARB_TIMEOUT_EN is defined.
module tb_mc_slave_result_arbiter;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int IW = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_slave_result_arbiter_if #(.NUM_SLAVES(N), .DATA_W(DW), .ID_W(IW)) bus ();

    mc_slave_result_arbiter #(
        .NUM_SLAVES(N), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYC(TO)
    ) dut (
        .Clock_pin(clk),
        .Reset_pin(rst),
        .bus(bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.S_req = 3'b111; bus.M_ack = 1'b0;
        tick(); tick();
        checks++; if (bus.M_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.M_valid); end
        checks++; if (bus.M_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.M_data); end
        checks++; if (bus.M_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.M_id); end
        checks++; if (bus.S_ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b want 000", bus.S_ack); end
        checks++; if (bus.Arb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.Arb_err); end
        rst = 1'b0;
        tick();
        checks++; if (bus.M_valid !== 1'b1) begin errors++; $display("FAIL first_grant_valid: got %b want 1", bus.M_valid); end
        checks++; if (bus.M_id !== 2'd0) begin errors++; $display("FAIL first_grant_id: got %0d want 0", bus.M_id); end
        checks++; if (bus.M_data !== 8'h11) begin errors++; $display("FAIL first_grant_data: got %h want 11", bus.M_data); end
        bus.M_ack = 1'b1;
        tick();
        checks++; if (bus.S_ack !== 3'b001) begin errors++; $display("FAIL first_ack: got %b want 001", bus.S_ack); end
        bus.M_ack = 1'b0; bus.S_req = 3'b000;
        tick(); tick();
    endtask

    task automatic test_single;
        bus.S_data = {8'h33, 8'hA5, 8'h11};
        bus.S_req  = 3'b010;
        tick();
        checks++; if (bus.M_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.M_valid); end
        checks++; if (bus.M_id !== 2'd1) begin errors++; $display("FAIL single_id: got %0d want 1", bus.M_id); end
        checks++; if (bus.M_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", bus.M_data); end
        // Winner withdraws during the offer: the offer must stand.
        bus.S_req = 3'b000;
        tick();
        checks++; if (bus.M_valid !== 1'b1 || bus.M_data !== 8'hA5) begin
            errors++; $display("FAIL single_hold: valid %b data %h want 1 a5", bus.M_valid, bus.M_data); end
        tick();
        bus.M_ack = 1'b1;
        tick();
        checks++; if (bus.M_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", bus.M_valid); end
        checks++; if (bus.S_ack !== 3'b010) begin errors++; $display("FAIL single_ack: got %b want 010", bus.S_ack); end
        bus.M_ack = 1'b0;
        tick();
        checks++; if (bus.S_ack !== 3'b000) begin errors++; $display("FAIL single_ack_pulse: got %b want 000", bus.S_ack); end
        tick();
    endtask

    task automatic test_broadcast;
        bus.S_rdy = 3'b101; #1;
        checks++; if (bus.Bcast_rdy !== 1'b0) begin errors++; $display("FAIL bcast_101: got %b want 0", bus.Bcast_rdy); end
        bus.S_rdy = 3'b111; #1;
        checks++; if (bus.Bcast_rdy !== 1'b1) begin errors++; $display("FAIL bcast_111: got %b want 1", bus.Bcast_rdy); end
        rst = 1'b1;
        tick();
        checks++; if (bus.Bcast_rdy !== 1'b1) begin errors++; $display("FAIL bcast_in_reset: got %b want 1", bus.Bcast_rdy); end
        rst = 1'b0;
        bus.S_rdy = 3'b011; #1;
        checks++; if (bus.Bcast_rdy !== 1'b0) begin errors++; $display("FAIL bcast_011: got %b want 0", bus.Bcast_rdy); end
        tick();
    endtask

    task automatic test_round_robin;
        int got;
        got = 0;
        bus.S_req = 3'b111;
        bus.M_ack = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            tick();
            if (bus.M_valid === 1'b1) begin
                checks++;
                if (bus.M_id !== 2'(got % 3)) begin
                    errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", got, bus.M_id, got % 3);
                end
                got++;
            end
            // Each slave drops its request the cycle it sees S_ack, then re-raises.
            bus.S_req = ~bus.S_ack;
        end
        checks++; if (got != 6) begin errors++; $display("FAIL rr_timeout: got %0d grants want 6", got); end
        tick();
        bus.M_ack = 1'b0; bus.S_req = 3'b000;
        tick(); tick();
    endtask

    task automatic test_reset_mid_offer;
        bus.S_data = {8'h33, 8'h22, 8'h11};
        bus.S_req  = 3'b001;
        tick();
        bus.M_ack = 1'b1;
        tick();
        bus.M_ack = 1'b0; bus.S_req = 3'b000;
        tick(); tick();
        // rr pointer is now 1; offer slave 2 then reset during the offer.
        bus.S_req = 3'b100;
        tick();
        checks++; if (bus.M_valid !== 1'b1 || bus.M_id !== 2'd2) begin
            errors++; $display("FAIL mid_offer_setup: valid %b id %0d want 1 2", bus.M_valid, bus.M_id); end
        rst = 1'b1; bus.M_ack = 1'b1;
        tick();
        checks++; if (bus.M_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", bus.M_valid); end
        checks++; if (bus.S_ack !== 3'b000) begin errors++; $display("FAIL mid_reset_ack: got %b want 000", bus.S_ack); end
        checks++; if (bus.M_id !== 2'd0 || bus.M_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset_latch: id %0d data %h want 0 00", bus.M_id, bus.M_data); end
        rst = 1'b0; bus.M_ack = 1'b0; bus.S_req = 3'b111;
        tick();
        checks++; if (bus.M_valid !== 1'b1 || bus.M_id !== 2'd0) begin
            errors++; $display("FAIL mid_reset_rrptr: valid %b id %0d want 1 0", bus.M_valid, bus.M_id); end
        bus.M_ack = 1'b1;
        tick();
        bus.M_ack = 1'b0; bus.S_req = 3'b000;
        tick(); tick();
    endtask

    task automatic test_release_hold;
        bus.S_req = 3'b010;
        tick();
        checks++; if (bus.M_valid !== 1'b1 || bus.M_id !== 2'd1) begin
            errors++; $display("FAIL hold_grant: valid %b id %0d want 1 1", bus.M_valid, bus.M_id); end
        bus.M_ack = 1'b1;
        tick();
        checks++; if (bus.S_ack !== 3'b010) begin errors++; $display("FAIL hold_ack: got %b want 010", bus.S_ack); end
        // Winner keeps requesting and slave 0 joins: no grant while the stale request stays up.
        bus.M_ack = 1'b0; bus.S_req = 3'b011;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.M_valid !== 1'b0) begin errors++; $display("FAIL hold_no_regrant[%0d]: got %b want 0", k, bus.M_valid); end
        end
        bus.S_req = 3'b001;
        tick(); tick();
        checks++; if (bus.M_valid !== 1'b1 || bus.M_id !== 2'd0 || bus.M_data !== 8'h11) begin
            errors++; $display("FAIL hold_pending_grant: valid %b id %0d data %h want 1 0 11", bus.M_valid, bus.M_id, bus.M_data); end
        bus.M_ack = 1'b1;
        tick();
        bus.M_ack = 1'b0; bus.S_req = 3'b000;
        tick(); tick();
    endtask

    task automatic test_timeout;
        bus.S_req = 3'b001; bus.M_ack = 1'b0;
        tick();
        checks++; if (bus.M_valid !== 1'b1) begin errors++; $display("FAIL to_offer: got %b want 1", bus.M_valid); end
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++; if (bus.M_valid !== 1'b1) begin errors++; $display("FAIL to_wait[%0d]: got %b want 1", k, bus.M_valid); end
        end
        tick();
        checks++; if (bus.M_valid !== 1'b0) begin errors++; $display("FAIL to_drop: got %b want 0", bus.M_valid); end
        checks++; if (bus.Arb_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", bus.Arb_err); end
        checks++; if (bus.S_ack !== 3'b001) begin errors++; $display("FAIL to_ack: got %b want 001", bus.S_ack); end
        bus.S_req = 3'b000;
        tick(); tick(); tick();
        checks++; if (bus.Arb_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", bus.Arb_err); end
`else
        repeat (10) tick();
        checks++; if (bus.M_valid !== 1'b1) begin errors++; $display("FAIL no_to_wait: got %b want 1", bus.M_valid); end
        checks++; if (bus.Arb_err !== 1'b0) begin errors++; $display("FAIL no_to_err: got %b want 0", bus.Arb_err); end
        bus.M_ack = 1'b1;
        tick();
        checks++; if (bus.S_ack !== 3'b001) begin errors++; $display("FAIL no_to_ack: got %b want 001", bus.S_ack); end
        bus.M_ack = 1'b0; bus.S_req = 3'b000;
        tick(); tick();
`endif
    endtask

    initial begin
        rst        = 1'b1;
        bus.S_req  = 3'b000;
        bus.S_data = {8'h33, 8'h22, 8'h11};
        bus.S_rdy  = 3'b000;
        bus.M_ack  = 1'b0;
        test_reset();
        test_single();
        test_broadcast();
        test_round_robin();
        test_reset_mid_offer();
        test_release_hold();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
